// File: rtl/count_seq_ctrl.sv
// Sequencer for an external 7-bit counter: clear, count to a latched target, pulse done.
// Optional REPEAT_EN macro adds a reps port and re-runs the count reps extra times before done.
module count_seq_ctrl (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic [6:0] max_count,
  input  logic       pause,
  input  logic [6:0] count_in,
`ifdef REPEAT_EN
  input  logic [3:0] reps,
`endif
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, CLEAR, COUNT, DONE} state_t;

  localparam logic [6:0] MaxTarget = 7'd99;

  state_t     state_q, state_d;
  logic [6:0] target_q, target_d;
  logic       err_q, err_d;
`ifdef REPEAT_EN
  logic [3:0] remain_q, remain_d;
`endif

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    err_d    = err_q;
`ifdef REPEAT_EN
    remain_d = remain_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          target_d = (max_count > MaxTarget) ? MaxTarget : max_count;
          err_d    = (max_count > MaxTarget);
`ifdef REPEAT_EN
          remain_d = reps;
`endif
          state_d  = CLEAR;
        end
      end
      CLEAR: state_d = COUNT;
      // Pause only masks the enable; reaching the target ends the run even while paused.
      COUNT: begin
        if (count_in >= target_q) state_d = DONE;
      end
      DONE: begin
`ifdef REPEAT_EN
        if (remain_q != '0) begin
          remain_d = remain_q - 4'd1;
          state_d  = CLEAR;
        end else begin
          state_d  = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      target_q <= '0;
      err_q    <= 1'b0;
`ifdef REPEAT_EN
      remain_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      err_q    <= err_d;
`ifdef REPEAT_EN
      remain_q <= remain_d;
`endif
    end
  end

  // Outputs decode the registered state so reset forces them low immediately.
  always_comb begin
    cnt_clr = (state_q == CLEAR);
    cnt_en  = (state_q == COUNT) && !pause && (count_in < target_q);
    busy    = (state_q != IDLE);
`ifdef REPEAT_EN
    done    = (state_q == DONE) && (remain_q == '0);
`else
    done    = (state_q == DONE);
`endif
    err     = err_q;
  end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: per-cycle vector table plus multi-cycle run sequences.
// An ideal external counter is modelled here and fed back on count_in.
module tb_count_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       start = 1'b0;
  logic [6:0] max_count = '0;
  logic       pause = 1'b0;
  logic [6:0] count_in;
`ifdef REPEAT_EN
  logic [3:0] reps = '0;
`endif
  logic       cnt_en, cnt_clr, busy, done, err;
  logic [6:0] cnt_model = '0;
  logic [4:0] outs;

  int n_chk  = 0;
  int n_pass = 0;

  count_seq_ctrl dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .start     (start),
    .max_count (max_count),
    .pause     (pause),
    .count_in  (count_in),
`ifdef REPEAT_EN
    .reps      (reps),
`endif
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (cnt_clr)     cnt_model <= '0;
    else if (cnt_en) cnt_model <= cnt_model + 7'd1;
  end

  assign count_in = cnt_model;
  assign outs     = {cnt_en, cnt_clr, busy, done, err};

  typedef struct {
    logic       rst_n;
    logic       start;
    logic [6:0] max_count;
    logic       pause;
    logic [4:0] exp;   // {cnt_en, cnt_clr, busy, done, err}
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic run(input logic [6:0] mc, input logic [3:0] rp, input int p_at,
                     input int p_len, input int s_at, output int n_en, output int n_clr,
                     output int n_done, output int done_at, output int to);
    n_en = 0; n_clr = 0; n_done = 0; done_at = -1; to = 1;
    start = 1'b1; max_count = mc; pause = 1'b0;
`ifdef REPEAT_EN
    reps = rp;
`else
    if (rp != 4'd0) $display("note: reps ignored without REPEAT_EN");
`endif
    @(posedge CLK); #1;
    start = 1'b0; max_count = ~mc;
    for (int k = 1; k < 600; k++) begin
      pause = (k >= p_at) && (k < p_at + p_len);
      start = (k == s_at);
      @(negedge CLK);
      if (cnt_en)  n_en++;
      if (cnt_clr) n_clr++;
      if (done) begin n_done++; done_at = k; end
      if (!busy) begin to = 0; break; end
      @(posedge CLK); #1;
    end
    start = 1'b0; pause = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin
    int n_en, n_clr, n_done, done_at, to, found, bad;

    //            rst  st   mc     pause exp{en,clr,busy,done,err}
    vecs[0]  = '{1'b0, 1'b0, 7'd0,  1'b0, 5'b00000};
    vecs[1]  = '{1'b1, 1'b1, 7'd5,  1'b0, 5'b00000};
    vecs[2]  = '{1'b1, 1'b0, 7'd5,  1'b0, 5'b01100};
    vecs[3]  = '{1'b1, 1'b0, 7'd5,  1'b0, 5'b10100};
    vecs[4]  = '{1'b1, 1'b1, 7'd50, 1'b0, 5'b10100};
    vecs[5]  = '{1'b1, 1'b0, 7'd50, 1'b0, 5'b10100};
    vecs[6]  = '{1'b1, 1'b0, 7'd50, 1'b0, 5'b10100};
    vecs[7]  = '{1'b1, 1'b0, 7'd50, 1'b0, 5'b10100};
    vecs[8]  = '{1'b1, 1'b0, 7'd50, 1'b0, 5'b00100};
    vecs[9]  = '{1'b1, 1'b1, 7'd50, 1'b0, 5'b00110};
    vecs[10] = '{1'b1, 1'b0, 7'd0,  1'b0, 5'b00000};
    vecs[11] = '{1'b1, 1'b0, 7'd0,  1'b0, 5'b00000};
    vecs[12] = '{1'b1, 1'b1, 7'd0,  1'b0, 5'b00000};
    vecs[13] = '{1'b1, 1'b0, 7'd0,  1'b0, 5'b01100};
    vecs[14] = '{1'b1, 1'b0, 7'd0,  1'b0, 5'b00100};
    vecs[15] = '{1'b1, 1'b0, 7'd0,  1'b0, 5'b00110};
    vecs[16] = '{1'b1, 1'b0, 7'd0,  1'b0, 5'b00000};
    vecs[17] = '{1'b1, 1'b1, 7'd2,  1'b0, 5'b00000};
    vecs[18] = '{1'b1, 1'b0, 7'd2,  1'b0, 5'b01100};
    vecs[19] = '{1'b1, 1'b0, 7'd2,  1'b1, 5'b00100};
    vecs[20] = '{1'b1, 1'b0, 7'd2,  1'b0, 5'b10100};
    vecs[21] = '{1'b1, 1'b0, 7'd2,  1'b0, 5'b10100};
    vecs[22] = '{1'b1, 1'b0, 7'd2,  1'b1, 5'b00100};
    vecs[23] = '{1'b1, 1'b0, 7'd2,  1'b0, 5'b00110};
    vecs[24] = '{1'b1, 1'b0, 7'd2,  1'b0, 5'b00000};

    for (int i = 0; i < 25; i++) begin
      RST_N = vecs[i].rst_n; start = vecs[i].start;
      max_count = vecs[i].max_count; pause = vecs[i].pause;
      @(negedge CLK);
      chk($sformatf("vec%0d", i), int'(outs), int'(vecs[i].exp));
      @(posedge CLK); #1;
    end
    start = 1'b0; pause = 1'b0;

    // Over-range request: clamps to 99 and sets err
    run(7'd120, 4'd0, 0, 0, 0, n_en, n_clr, n_done, done_at, to);
    chk("ovr_timeout", to, 0);
    chk("ovr_en_cycles", n_en, 99);
    chk("ovr_done_pulses", n_done, 1);
    chk("ovr_done_at", done_at, 102);
    chk("ovr_final_count", int'(cnt_model), 99);
    chk("ovr_err_sticky", int'(err), 1);

    run(7'd10, 4'd0, 0, 0, 0, n_en, n_clr, n_done, done_at, to);
    chk("t10_en_cycles", n_en, 10);
    chk("t10_err_cleared", int'(err), 0);

    // Pause for 4 count cycles, stray start mid-run
    run(7'd20, 4'd0, 5, 4, 12, n_en, n_clr, n_done, done_at, to);
    chk("pause_timeout", to, 0);
    chk("pause_en_cycles", n_en, 20);
    chk("pause_clr_pulses", n_clr, 1);
    chk("pause_done_at", done_at, 27);
    @(negedge CLK);
    chk("pause_idle_after", int'(busy), 0);
    @(posedge CLK); #1;

    // Reset mid-run at count 12
    start = 1'b1; max_count = 7'd30;
    @(posedge CLK); #1;
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (cnt_model == 7'd12) begin found = 1; break; end
    end
    chk("rst_reach12", found, 1);
    #1 RST_N = 1'b0;
    #1 chk("rst_async_outs", int'(outs), 0);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      if (outs != '0) bad++;
    end
    chk("rst_hold_outs", bad, 0);
    @(posedge CLK); #1 RST_N = 1'b1;
    @(posedge CLK); #1;

    run(7'd3, 4'd0, 0, 0, 0, n_en, n_clr, n_done, done_at, to);
    chk("post_rst_en", n_en, 3);
    chk("post_rst_clr", n_clr, 1);
    chk("post_rst_done_at", done_at, 6);
    chk("post_rst_done_pulses", n_done, 1);

`ifdef REPEAT_EN
    run(7'd4, 4'd2, 0, 0, 0, n_en, n_clr, n_done, done_at, to);
    chk("rep_clr_pulses", n_clr, 3);
    chk("rep_en_cycles", n_en, 12);
    chk("rep_done_pulses", n_done, 1);
    chk("rep_done_at", done_at, 21);
`else
    run(7'd4, 4'd0, 0, 0, 0, n_en, n_clr, n_done, done_at, to);
    chk("single_clr_pulses", n_clr, 1);
    chk("single_en_cycles", n_en, 4);
    chk("single_done_pulses", n_done, 1);
    chk("single_done_at", done_at, 7);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/count_seq_ctrl.md
COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 RST_N  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to begin a count run; sampled only in IDLE.
REQ-005 max_count  input  7  requested terminal count; latched when start is accepted.
REQ-006 pause  input  1  level; freezes counting while high in COUNT.
REQ-007 count_in  input  7  current value from the external 7-bit counter.
REQ-008 cnt_en  output  1  counter increment enable; the counter clock is never gated.
REQ-009 cnt_clr  output  1  synchronous clear to the counter.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse when a run completes.
REQ-012 err  output  1  sticky flag set when the requested max_count exceeds 99.
REQ-013 reps  input  4  extra repetitions; the port SHALL exist only when REPEAT_EN is defined.

Function
REQ-014 The FSM SHALL have the states IDLE, CLEAR, COUNT and DONE.
REQ-015 IDLE with start=1: latch target = min(max_count, 99), set err = (max_count > 99), next state CLEAR.
REQ-016 IDLE with start=0: remain in IDLE; the target register holds its value.
REQ-017 CLEAR: cnt_clr=1 for exactly one cycle, cnt_en=0, next state COUNT.
REQ-018 COUNT: cnt_en = !pause && (count_in < target); cnt_clr=0.
REQ-019 COUNT with count_in >= target: cnt_en=0, next state DONE; this applies regardless of pause.
REQ-020 DONE: done=1 for one cycle, then next state IDLE.
REQ-021 Latency: if start is accepted at edge E, done SHALL be high in the cycle after edge E+T+2 (T = target), given an ideal counter that increments on each cnt_en.
REQ-022 start asserted in any state other than IDLE SHALL be ignored; max_count changes outside IDLE SHALL have no effect.
REQ-023 Target 0: COUNT sees count_in=0 on entry and goes directly to DONE; cnt_en is never asserted.
REQ-024 start high in the DONE cycle SHALL be ignored; a new run requires start sampled in IDLE.
REQ-025 err SHALL clear only on reset or on the next accepted start with max_count <= 99.
REQ-026 All outputs SHALL be decoded from registered state and the target register; cnt_en additionally depends combinationally on pause and count_in.

Reset
REQ-027 While RST_N=0: state=IDLE, target=0, err=0, repetition counter=0.
REQ-028 While RST_N=0: cnt_en=0, cnt_clr=0, busy=0, done=0.
REQ-029 Reset asserted mid-run SHALL abort immediately with no done pulse.
REQ-030 After release of RST_N, the first accepted start SHALL behave identically to one following a completed run.

Configuration
REQ-031 Macro REPEAT_EN defined: reps is latched with start, and a remaining-repetitions counter is loaded from it.
REQ-032 With REPEAT_EN: DONE with remaining > 0 decrements remaining, does not pulse done, and goes to CLEAR; done pulses only after the final run (reps+1 runs in total).
REQ-033 Macro REPEAT_EN undefined: the reps port and the repetition counter are absent, and every run ends with a done pulse.

Verification
REQ-034 Reset, then start with max_count=5 -> cnt_clr high 1 cycle, cnt_en high for exactly 5 cycles, done pulse at 8 cycles after accept, busy low afterwards.
REQ-035 start with max_count=0 -> cnt_en never high, done pulse 3 cycles after accept.
REQ-036 start with max_count=120 -> err=1, counting stops at 99, done pulses once; next start with max_count=10 -> err=0.
REQ-037 max_count=20 with pause held for 4 cycles mid-run, plus a start pulse mid-run -> cnt_en low during pause, done 4 cycles later than unpaused, second start ignored.
REQ-038 max_count=30, RST_N asserted at count 12 -> all outputs 0 immediately, no done pulse; next run with max_count=3 is correct.
REQ-039 With REPEAT_EN, max_count=4 and reps=2 -> three cnt_clr pulses, 12 total cnt_en cycles, exactly one done pulse.
